two_pulses_gen: RTL and testbench
=================================

Name: two_pulses_gen

Overview:
- Stimulus generator for the x/y pulse protocol: emits an opening x pulse, a programmable number of y pulses, a closing x pulse, and an optional terminating y pulse.
- Default config (2 y pulses) produces the exact sequence that makes the two-pulse detector assert its output. Other counts produce negative sequences.
- Sits upstream of the detector in block-level benches and in the self-test path. Driven by a simple start/busy/done handshake.

Parameters:
- CNT_W, 8, width of y-count and gap fields and internal counters
- DEF_Y, 2, y count used when cfg_default_i = 1

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start_i  input  1  1-cycle request to begin a sequence; sampled only in IDLE
- cfg_default_i  input  1  1: use DEF_Y as y count; 0: use y_count_i
- y_count_i  input  CNT_W  number of y pulses between the two x pulses
- gap_i  input  CNT_W  idle cycles inserted after every pulse
- term_y_i  input  1  1: emit a trailing y pulse after the closing x
- x_o  output  1  x pulse, 1 cycle wide
- y_o  output  1  y pulse, 1 cycle wide
- busy_o  output  1  high from the cycle after accepted start until done
- done_o  output  1  1-cycle completion strobe

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset: state IDLE, all counters 0, x_o = y_o = busy_o = done_o = 0.
- Reset asserted mid-sequence aborts the sequence on the next edge. No partial pulse follows.
- All outputs are registered. x_o and y_o are never high in the same cycle.
- Config capture: on start_i in IDLE, latch the y count (DEF_Y or y_count_i), gap_i and term_y_i.
  - Config changes after acceptance have no effect.
  - start_i while busy is ignored and not queued.
- States: IDLE, X_OPEN, Y_PULSE, X_CLOSE, TERM_Y, GAP, DONE.
- IDLE:
  - start_i -> X_OPEN.
- X_OPEN:
  - x_o = 1 for 1 cycle.
  - Next: GAP, tagged to return to Y_PULSE, or to X_CLOSE if y count = 0.
- GAP:
  - Outputs low for exactly the latched gap cycles.
  - gap = 0 skips GAP entirely, giving back-to-back pulses on consecutive cycles.
  - The gap counter loads at entry and decrements to 0. No wrap.
- Y_PULSE:
  - y_o = 1, y counter += 1.
  - If the counter equals the latched count -> GAP then X_CLOSE; else -> GAP then Y_PULSE.
  - The counter is CNT_W wide. Count 2^CNT_W-1 is legal, with no overflow because the compare precedes the increment wrap.
- X_CLOSE:
  - x_o = 1.
  - Next: GAP then TERM_Y if term_y latched; else DONE.
- TERM_Y:
  - y_o = 1.
  - Next: DONE. No gap after the terminating y.
- DONE:
  - done_o = 1 for 1 cycle, busy_o = 0 in the same cycle.
  - Next: IDLE.
  - start_i in DONE is ignored; start is accepted from the following IDLE cycle.
- busy_o: 1 from X_OPEN through the cycle before DONE.
- Latency:
  - start_i sampled at edge N -> x_o high in cycle N+1.
  - Total length = 2 + Y + T + (1+Y+T)·G + 1 cycles, where Y = y count, T = term_y, G = gap.

Decomposition:
- Shared package two_pulses_pkg:
  - State enum typedef (2'b/3'b encoded, with default X state for lint/X-prop checks).
  - CNT_W default.
  - DEF_Y constant, shared with the detector's y-count target.
- No sub-module needed. One FSM, a gap down-counter and a y up-counter, all in one module.

Test Plan:
- cfg_default_i = 1, gap = 0, term_y = 0, start at cycle 0 -> x_o @1, y_o @2, y_o @3, x_o @4, done_o @5. Downstream detector output goes high @4.
- y_count = 3, gap = 2, term_y = 1 -> x, 2 idle, y, 2 idle, y, 2 idle, y, 2 idle, x, 2 idle, y, done. Total 17 cycles after start. Detector stays low.
- y_count = 0, gap = 1 -> x @1, idle @2, x @3, done @4. No y_o ever asserted.
- start_i re-pulsed at cycles 2 and 3 during a busy sequence, and again in the DONE cycle -> all ignored. Exactly one sequence and one done_o. Next start is accepted only in IDLE.
- reset asserted in cycle 3 of a gap = 0 default sequence -> from the next edge x_o = y_o = busy_o = done_o = 0 and state is IDLE. A new start then produces a full correct sequence.
- y_count = 255, gap = 0 -> exactly 255 y pulses and no wrap. x_o appears at cycle 257, done_o at cycle 258.

Source files
------------

// File: rtl/two_pulses_pkg.sv
// Shared definitions for the x/y pulse stimulus generator and its
// downstream two-pulse detector.
package two_pulses_pkg;

  // Default width of the y-count and gap fields and of the internal counters.
  localparam int TP_CNT_W = 8;

  // Number of y pulses in the positive sequence. The detector uses the same
  // value as its y-count target.
  localparam int TP_DEF_Y = 2;

  // Width of the state encoding.
  localparam int TP_STATE_W = 3;

  // Generator states. Code 3'b111 is unused. The FSM recovers from it to IDLE.
  typedef enum logic [TP_STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_X_OPEN  = 3'd1,
    ST_Y_PULSE = 3'd2,
    ST_X_CLOSE = 3'd3,
    ST_TERM_Y  = 3'd4,
    ST_GAP     = 3'd5,
    ST_DONE    = 3'd6
  } tp_state_e;

  // True for the states that drive a pulse on x_o.
  function automatic logic tp_is_x(input tp_state_e s);
    return (s == ST_X_OPEN) || (s == ST_X_CLOSE);
  endfunction

  // True for the states that drive a pulse on y_o.
  function automatic logic tp_is_y(input tp_state_e s);
    return (s == ST_Y_PULSE) || (s == ST_TERM_Y);
  endfunction

endpackage

// File: rtl/two_pulses_gen.sv
// Stimulus generator for the x/y pulse protocol. It emits an opening x, a
// programmable number of y pulses, a closing x and an optional trailing y.
// It can insert idle gap cycles after each pulse. All outputs are registered.
//
// Handshake: start_i is sampled only in IDLE. An accepted start raises busy_o
// from the next cycle, which is also the cycle of the opening x pulse.
// busy_o stays high until the cycle before DONE. In the DONE cycle done_o is
// high for exactly one cycle and busy_o is low. Any start_i seen while busy,
// or in the DONE cycle, is dropped and not queued.
module two_pulses_gen
  import two_pulses_pkg::*;
#(
  parameter int CNT_W = TP_CNT_W,
  parameter int DEF_Y = TP_DEF_Y
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  cfg_default_i,
  input  logic [CNT_W-1:0]      y_count_i,
  input  logic [CNT_W-1:0]      gap_i,
  input  logic                  term_y_i,
  output logic                  x_o,
  output logic                  y_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [TP_STATE_W-1:0] state_dbg_o
);

  localparam logic [CNT_W-1:0] DEF_Y_C = CNT_W'(DEF_Y);

  // FSM state and the state that GAP returns to.
  tp_state_e state_q, state_d;
  tp_state_e ret_q, ret_d;

  // Configuration latched when start is accepted.
  logic [CNT_W-1:0] y_lat_q, y_lat_d;
  logic [CNT_W-1:0] gap_lat_q, gap_lat_d;
  logic             term_lat_q, term_lat_d;

  // Gap down-counter and y up-counter.
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] y_cnt_q, y_cnt_d;
  logic [CNT_W-1:0] y_cnt_inc;

  // Registered outputs.
  logic x_q, x_d;
  logic y_q, y_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Set by a pulse state: the pulse is over, continue at 'resume'. A GAP
  // stretch is inserted first when a non-zero gap was latched.
  logic      pulse_end;
  tp_state_e resume;

  assign y_cnt_inc = y_cnt_q + 1'b1;

  // Next-state logic: sequence walk, config capture and counters.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    y_lat_d    = y_lat_q;
    gap_lat_d  = gap_lat_q;
    term_lat_d = term_lat_q;
    gap_cnt_d  = gap_cnt_q;
    y_cnt_d    = y_cnt_q;
    pulse_end  = 1'b0;
    resume     = ST_IDLE;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_X_OPEN;
          y_lat_d    = cfg_default_i ? DEF_Y_C : y_count_i;
          gap_lat_d  = gap_i;
          term_lat_d = term_y_i;
          y_cnt_d    = '0;
          gap_cnt_d  = '0;
        end
      end

      ST_X_OPEN: begin
        pulse_end = 1'b1;
        resume    = (y_lat_q == '0) ? ST_X_CLOSE : ST_Y_PULSE;
      end

      ST_Y_PULSE: begin
        // The compare uses the incremented value. It matches before the
        // counter could wrap, even for the largest count.
        y_cnt_d   = y_cnt_inc;
        pulse_end = 1'b1;
        resume    = (y_cnt_inc == y_lat_q) ? ST_X_CLOSE : ST_Y_PULSE;
      end

      ST_X_CLOSE: begin
        if (term_lat_q) begin
          pulse_end = 1'b1;
          resume    = ST_TERM_Y;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_TERM_Y: begin
        // The trailing y is never followed by a gap.
        state_d = ST_DONE;
      end

      ST_GAP: begin
        // The counter was loaded on entry. The last gap cycle is the one
        // that sees 1. The counter saturates at 0 and never wraps.
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
        if (gap_cnt_q <= CNT_W'(1)) begin
          state_d = ret_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pulse_end) begin
      if (gap_lat_q == '0) begin
        state_d = resume;
      end else begin
        state_d   = ST_GAP;
        ret_d     = resume;
        gap_cnt_d = gap_lat_q;
      end
    end
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe.
  always_comb begin
    x_d    = tp_is_x(state_d);
    y_d    = tp_is_y(state_d);
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  // State, counters, latched config and outputs. Reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_IDLE;
      y_lat_q    <= '0;
      gap_lat_q  <= '0;
      term_lat_q <= 1'b0;
      gap_cnt_q  <= '0;
      y_cnt_q    <= '0;
      x_q        <= 1'b0;
      y_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      y_lat_q    <= y_lat_d;
      gap_lat_q  <= gap_lat_d;
      term_lat_q <= term_lat_d;
      gap_cnt_q  <= gap_cnt_d;
      y_cnt_q    <= y_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_two_pulses_gen.sv
// Bench for two_pulses_gen. A reference model builds the per-cycle
// {x, y, busy, done} trace of each sequence into a queue. The trace is
// popped and compared cycle by cycle while the DUT runs.
module tb_two_pulses_gen;
  import two_pulses_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic       cfg_default_i;
  logic [7:0] y_count_i;
  logic [7:0] gap_i;
  logic       term_y_i;
  logic       x_o, y_o, busy_o, done_o;
  logic [2:0] state_dbg_o;

  always #5 clk = ~clk;

  two_pulses_gen dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .cfg_default_i (cfg_default_i),
    .y_count_i     (y_count_i),
    .gap_i         (gap_i),
    .term_y_i      (term_y_i),
    .x_o           (x_o),
    .y_o           (y_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .state_dbg_o   (state_dbg_o)
  );

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int         exp_y_pulses;
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_cyc(input logic x, input logic y, input logic busy, input logic done);
    exp_q.push_back({x, y, busy, done});
  endtask

  task automatic push_gap(input logic [7:0] gap);
    for (int g = 0; g < int'(gap); g++) push_cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Reference trace. The first entry is the cycle after start is sampled.
  // The trace ends with the DONE cycle and then one idle cycle.
  task automatic build_exp(input logic use_def, input logic [7:0] yc,
                           input logic [7:0] gap, input logic term);
    int ny;
    ny = use_def ? TP_DEF_Y : int'(yc);
    push_cyc(1'b1, 1'b0, 1'b1, 1'b0);
    push_gap(gap);
    for (int i = 0; i < ny; i++) begin
      push_cyc(1'b0, 1'b1, 1'b1, 1'b0);
      push_gap(gap);
    end
    push_cyc(1'b1, 1'b0, 1'b1, 1'b0);
    if (term) begin
      push_gap(gap);
      push_cyc(1'b0, 1'b1, 1'b1, 1'b0);
    end
    push_cyc(1'b0, 1'b0, 1'b0, 1'b1);
    push_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp_y_pulses = ny + int'(term);
  endtask

  // ---------------- driver ----------------
  // poke:   re-pulse start in cycles 2 and 3 and in the DONE cycle.
  // rst_at: assert reset in that cycle; 0 means no reset.
  // The config inputs are scrambled every cycle after the start cycle.
  task automatic run_seq(input string name, input logic use_def, input logic [7:0] yc,
                         input logic [7:0] gap, input logic term,
                         input logic poke, input int rst_at);
    int         n;
    int         ycount;
    logic [3:0] e;
    logic [3:0] got;
    ycount = 0;
    exp_q.delete();
    build_exp(use_def, yc, gap, term);
    if (rst_at > 0) begin
      while (exp_q.size() > rst_at) void'(exp_q.pop_back());
      push_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    n = exp_q.size();

    @(posedge clk); #1;
    start_i       = 1'b1;
    cfg_default_i = use_def;
    y_count_i     = yc;
    gap_i         = gap;
    term_y_i      = term;

    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      reset         = (rst_at > 0) && (c == rst_at);
      start_i       = poke && ((c == 2) || (c == 3) || (c == n - 1));
      cfg_default_i = 1'($urandom_range(0, 1));
      y_count_i     = 8'($urandom_range(0, 255));
      gap_i         = 8'($urandom_range(0, 255));
      term_y_i      = 1'($urandom_range(0, 1));
      @(negedge clk);
      e   = exp_q.pop_front();
      got = {x_o, y_o, busy_o, done_o};
      check($sformatf("%s_c%0d_xybd", name, c), 32'(got), 32'(e));
      check($sformatf("%s_c%0d_excl", name, c), 32'(x_o & y_o), 32'd0);
      if (y_o) ycount++;
    end
    check($sformatf("%s_end_state", name), 32'(state_dbg_o), 32'(ST_IDLE));
    if (rst_at == 0) check($sformatf("%s_ycount", name), 32'(ycount), 32'(exp_y_pulses));
    reset   = 1'b0;
    start_i = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    reset         = 1'b1;
    start_i       = 1'b0;
    cfg_default_i = 1'b0;
    y_count_i     = 8'd0;
    gap_i         = 8'd0;
    term_y_i      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_xybd", 32'({x_o, y_o, busy_o, done_o}), 32'd0);
    check("rst_state", 32'(state_dbg_o), 32'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_xybd", 32'({x_o, y_o, busy_o, done_o}), 32'd0);

    run_seq("def",     1'b1, 8'd7,   8'd0, 1'b0, 1'b0, 0);
    run_seq("y3g2t1",  1'b0, 8'd3,   8'd2, 1'b1, 1'b0, 0);
    run_seq("y0g1",    1'b0, 8'd0,   8'd1, 1'b0, 1'b0, 0);
    run_seq("poke",    1'b1, 8'd0,   8'd0, 1'b0, 1'b1, 0);
    run_seq("rst3",    1'b1, 8'd0,   8'd0, 1'b0, 1'b0, 3);
    run_seq("postrst", 1'b1, 8'd0,   8'd0, 1'b0, 1'b0, 0);
    run_seq("y255",    1'b0, 8'd255, 8'd0, 1'b0, 1'b0, 0);
    run_seq("pokeg3",  1'b0, 8'd4,   8'd3, 1'b1, 1'b1, 0);
    for (int k = 0; k < 6; k++) begin
      run_seq($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)),
              8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
